// File: rtl/mux_select_sequencer.sv
// Select sequencer for the 2-bit 4:1 data mux: auto rotation at a fixed dwell,
// manual stepping from a debounced pushbutton, and a direct load override.
module mux_select_sequencer #(
    parameter int TICK_DIV   = 25000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_sw,
    input  logic       step_btn_n,
    input  logic       dir,
    input  logic       load,
    input  logic [1:0] load_sel,
    output logic [1:0] select,
    output logic       step_pulse,
    output logic       mode_auto
);
    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        run_sync, btn_sync;
    logic              run_s, btn_s;
    logic              deb_state, deb_prev, press_evt;
    logic [DEB_W-1:0]  deb_cnt;
    logic [TICK_W-1:0] tick_cnt, tick_nxt;
    logic [1:0]        sel_nxt, sel_adv;
    logic              adv, pulse_nxt;

    // Two-stage synchronisers; the button idles released, the switch idles manual.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_sync <= 2'b00;
            btn_sync <= 2'b11;
        end else begin
            run_sync <= {run_sync[0], run_sw};
            btn_sync <= {btn_sync[0], step_btn_n};
        end
    end

    assign run_s = run_sync[1];
    assign btn_s = btn_sync[1];

    // A level change is accepted only after DEB_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_state <= 1'b1;
            deb_prev  <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            deb_prev <= deb_state;
            if (btn_s != deb_state) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_state <= btn_s;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign press_evt = deb_prev & ~deb_state;

    always_comb begin
        state_nxt = state;
        case (state)
            MANUAL:  if (run_s)  state_nxt = AUTO;
            AUTO:    if (!run_s) state_nxt = MANUAL;
            default: state_nxt = MANUAL;
        endcase
    end

    assign sel_adv = dir ? (select - 2'd1) : (select + 2'd1);

    always_comb begin
        adv       = 1'b0;
        tick_nxt  = '0;
        sel_nxt   = select;
        pulse_nxt = 1'b0;

        if (state == AUTO) begin
            if (tick_cnt == TICK_LAST) begin
                adv      = 1'b1;
                tick_nxt = '0;
            end else begin
                tick_nxt = tick_cnt + TICK_W'(1);
            end
        end else begin
            adv = press_evt;
        end

        if (state_nxt != state)
            tick_nxt = '0;

        // Load wins outright; a coincident advance is dropped, not deferred.
        if (load) begin
            sel_nxt  = load_sel;
            tick_nxt = '0;
        end else if (adv) begin
            sel_nxt   = sel_adv;
            pulse_nxt = 1'b1;
        end
    end

    // mode_auto tracks the next state so it lands on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= MANUAL;
            mode_auto  <= 1'b0;
            tick_cnt   <= '0;
            select     <= 2'b00;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            mode_auto  <= (state_nxt == AUTO);
            tick_cnt   <= tick_nxt;
            select     <= sel_nxt;
            step_pulse <= pulse_nxt;
        end
    end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Bench for mux_select_sequencer: directed scenarios plus random traffic,
// each cycle compared against a behavioural model of the select sequence.
module tb_mux_select_sequencer;
    localparam int TICK_DIV   = 5;
    localparam int DEB_CYCLES = 4;

    logic       clk = 1'b0;
    logic       reset_n, run_sw, step_btn_n, dir, load;
    logic [1:0] load_sel;
    logic [1:0] select;
    logic       step_pulse, mode_auto;

    int checks = 0;
    int errors = 0;
    int npulse = 0;

    mux_select_sequencer #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n), .run_sw(run_sw), .step_btn_n(step_btn_n),
        .dir(dir), .load(load), .load_sel(load_sel),
        .select(select), .step_pulse(step_pulse), .mode_auto(mode_auto)
    );

    always #5 clk = ~clk;

    // Reference model: input delay lines, a stable-run counter for the button,
    // and the select value as an integer mod 4.
    bit m_run[2];
    bit m_btn[2];
    bit m_deb, m_deb_prev, m_mode, m_pulse;
    int m_diff, m_tick, m_sel;

    task automatic model_reset();
        m_run[0] = 0; m_run[1] = 0;
        m_btn[0] = 1; m_btn[1] = 1;
        m_deb = 1; m_deb_prev = 1; m_mode = 0; m_pulse = 0;
        m_diff = 0; m_tick = 0; m_sel = 0;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            bit o_rs, o_bs, o_deb, o_mode, press, adv, entry;
            int o_tick, o_sel;
            o_rs = m_run[1]; o_bs = m_btn[1]; o_deb = m_deb; o_mode = m_mode;
            o_tick = m_tick; o_sel = m_sel;
            press = m_deb_prev && !m_deb;

            m_run[1] = m_run[0]; m_run[0] = run_sw;
            m_btn[1] = m_btn[0]; m_btn[0] = step_btn_n;

            m_diff = (o_bs != o_deb) ? m_diff + 1 : 0;
            if (m_diff == DEB_CYCLES) begin
                m_deb  = o_bs;
                m_diff = 0;
            end
            m_deb_prev = o_deb;

            m_mode = o_rs;
            entry  = (m_mode != o_mode);
            adv    = o_mode ? (o_tick == TICK_DIV - 1) : press;

            if (load || entry) m_tick = 0;
            else if (o_mode)   m_tick = (o_tick + 1) % TICK_DIV;
            else               m_tick = 0;

            if (load)     m_sel = int'(load_sel);
            else if (adv) m_sel = (o_sel + (dir ? 3 : 1)) % 4;
            m_pulse = adv && !load;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("model_sel", 32'(select), 32'(m_sel));
        chk("model_pulse", 32'(step_pulse), 32'(m_pulse));
        chk("model_mode", 32'(mode_auto), 32'(m_mode));
        if (step_pulse) npulse++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [1:0] v);
        load = 1'b1; load_sel = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        int k, hold;
        reset_n = 1'b0; run_sw = 1'b0; step_btn_n = 1'b1; dir = 1'b0;
        load = 1'b0; load_sel = 2'b00;
        #2;
        chk("rst_sel", 32'(select), 0);
        chk("rst_pulse", 32'(step_pulse), 0);
        chk("rst_mode", 32'(mode_auto), 0);
        #10 reset_n = 1'b1;

        // Idle manual mode.
        npulse = 0;
        steps(50);
        chk("idle_sel", 32'(select), 0);
        chk("idle_pulses", 32'(npulse), 0);

        // Auto rotation, count up.
        run_sw = 1'b1; dir = 1'b0;
        step(); chk("mode_edge1", 32'(mode_auto), 0);
        step(); chk("mode_edge2", 32'(mode_auto), 0);
        step(); chk("mode_edge3", 32'(mode_auto), 1);
        npulse = 0;
        steps(25);
        chk("auto_pulses", 32'(npulse), 5);
        chk("auto_sel", 32'(select), 1);

        // Manual press with bounces, dir down from 00.
        run_sw = 1'b0;
        steps(5);
        do_load(2'b00);
        dir = 1'b1; npulse = 0;
        step_btn_n = 0; steps(1); step_btn_n = 1; steps(2);
        step_btn_n = 0; steps(2); step_btn_n = 1; steps(1);
        step_btn_n = 0; steps(20);
        chk("press_pulses", 32'(npulse), 1);
        chk("press_sel", 32'(select), 3);
        npulse = 0;
        step_btn_n = 1; steps(1); step_btn_n = 0; steps(2);
        step_btn_n = 1; steps(20);
        chk("release_pulses", 32'(npulse), 0);
        chk("release_sel", 32'(select), 3);

        // Short glitch must not register.
        step_btn_n = 0; steps(3); step_btn_n = 1; steps(10);
        chk("glitch_sel", 32'(select), 3);

        // Load colliding with a tick wrap in auto mode.
        run_sw = 1'b1; dir = 1'b0;
        steps(3);
        k = 0;
        while (m_tick != TICK_DIV - 1 && k < 20) begin step(); k++; end
        chk("tick_align", 32'(k < 20), 1);
        npulse = 0;
        do_load(2'b10);
        chk("load_sel", 32'(select), 2);
        chk("load_pulse", 32'(step_pulse), 0);
        steps(4);
        chk("load_hold", 32'(select), 2);
        step();
        chk("load_next", 32'(select), 3);
        chk("load_pulses", 32'(npulse), 1);

        // Reset mid-dwell.
        do_load(2'b10);
        steps(2);
        reset_n = 1'b0;
        #1;
        chk("midrst_sel", 32'(select), 0);
        chk("midrst_mode", 32'(mode_auto), 0);
        steps(2);
        reset_n = 1'b1;
        steps(8);
        chk("restart_mode", 32'(mode_auto), 1);
        chk("restart_sel", 32'(select), 1);

        // Random traffic.
        hold = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 79) == 0) run_sw = ~run_sw;
            hold--;
            if (hold == 0) begin
                step_btn_n = ~step_btn_n;
                hold = $urandom_range(1, 9);
            end
            dir = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 24) == 0);
            load_sel = 2'($urandom_range(0, 3));
            step();
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
